// File: rtl/fxp_div_pkg.sv
// Shared types and constants for the streaming fixed-point divider wrapper:
// the result FIFO entry layout and the saturation values used on overflow.
package fxp_div_pkg;

    localparam int FXP_QW = 16;

    typedef struct packed {
        logic [FXP_QW-1:0] quot;
        logic              ovf;
    } fxp_entry_t;

    localparam logic [FXP_QW-1:0] SAT_POS = {1'b0, {(FXP_QW-1){1'b1}}};
    localparam logic [FXP_QW-1:0] SAT_NEG = {1'b1, {(FXP_QW-1){1'b0}}};

endpackage

// File: rtl/fxp_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on rd_data whenever !empty.
// Synchronous active-low reset; simultaneous write and read both take effect.
module fxp_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];

endmodule

// File: rtl/pipe_fxp_div_stream.sv
// Valid/ready wrapper around a free-running fixed-latency divider with a credit-guarded result FIFO.
// Define FXP_DIV_SAT_EN to replace overflowed quotients with the signed saturation value.
module pipe_fxp_div_stream
    import fxp_div_pkg::*;
#(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int LAT   = 16,
    parameter int DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WIIA+WIFA-1:0] i_dividend,
    input  logic [WIIB+WIFB-1:0] i_divisor,
    output logic [WIIA+WIFA-1:0] div_dividend,
    output logic [WIIB+WIFB-1:0] div_divisor,
    input  logic [WOI+WOF-1:0]   div_out,
    input  logic                 div_overflow,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WOI+WOF-1:0]   o_quot,
    output logic                 o_overflow,
    output logic [15:0]          ovf_cnt
);

    localparam int AW = WIIA + WIFA;
    localparam int BW = WIIB + WIFB;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef FXP_DIV_SAT_EN
    localparam int LW = 2;
`else
    localparam int LW = 1;
`endif

    logic          accept;
    logic          pop;
    logic          wr_en;
    logic          fifo_empty;
    logic [CW-1:0] credit_reg;
    logic [CW-1:0] credit_next;
    logic [LW-1:0] line_in;
    logic [LW-1:0] line_reg [LAT];
    logic [15:0]   ovf_cnt_reg;
    fxp_entry_t    wr_entry;
    fxp_entry_t    rd_entry;

    // Credit counts FIFO slots not yet promised to an operation in the divider.
    assign i_ready      = rst && (credit_reg != '0);
    assign accept       = i_valid && i_ready;
    assign o_valid      = rst && !fifo_empty;
    assign pop          = o_valid && o_ready;
    assign div_dividend = accept ? i_dividend : '0;
    assign div_divisor  = accept ? i_divisor  : '0;

    always_comb begin
        credit_next = credit_reg;
        if (accept && !pop)
            credit_next = credit_reg - 1'b1;
        else if (pop && !accept)
            credit_next = credit_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) credit_reg <= CW'(DEPTH);
        else      credit_reg <= credit_next;
    end

`ifdef FXP_DIV_SAT_EN
    assign line_in = {accept && (i_dividend[AW-1] ^ i_divisor[BW-1]), accept};
`else
    assign line_in = accept;
`endif

    // Delay line mirrors the divider pipeline; its tap marks the cycle div_out is meaningful.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) line_reg[i] <= '0;
        end else begin
            line_reg[0] <= line_in;
            for (int i = 1; i < LAT; i++) line_reg[i] <= line_reg[i-1];
        end
    end

    assign wr_en = line_reg[LAT-1][0];

    always_comb begin
        wr_entry.quot = div_out;
        wr_entry.ovf  = div_overflow;
`ifdef FXP_DIV_SAT_EN
        if (div_overflow)
            wr_entry.quot = line_reg[LAT-1][LW-1] ? SAT_NEG : SAT_POS;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst)
            ovf_cnt_reg <= '0;
        else if (wr_en && div_overflow && (ovf_cnt_reg != 16'hFFFF))
            ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
    end

    assign ovf_cnt = ovf_cnt_reg;

    fxp_sync_fifo #(
        .WIDTH($bits(fxp_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_entry),
        .rd_en  (pop),
        .rd_data(rd_entry),
        .empty  (fifo_empty)
    );

    assign o_quot     = rd_entry.quot;
    assign o_overflow = rd_entry.ovf;

endmodule

// File: tb/tb_pipe_fxp_div_stream.sv
// Scoreboard bench for pipe_fxp_div_stream with a behavioural fixed-latency 8.8 divider.
// Expected quotients depend on whether FXP_DIV_SAT_EN is defined for the build.
module tb_pipe_fxp_div_stream;

    localparam int LAT   = 16;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [15:0] i_dividend = '0;
    logic [15:0] i_divisor = '0;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_out;
    logic        div_overflow;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [15:0] o_quot;
    logic        o_overflow;
    logic [15:0] ovf_cnt;

    typedef struct {
        logic [15:0] q;
        logic        o;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic        bulk = 1'b0;
    logic        force_ovf = 1'b0;
    logic [16:0] dpipe [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_fxp_div_stream #(
        .WIIA(8), .WIFA(8), .WIIB(8), .WIFB(8), .WOI(8), .WOF(8),
        .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor),
        .div_out     (div_out),
        .div_overflow(div_overflow),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_quot      (o_quot),
        .o_overflow  (o_overflow),
        .ovf_cnt     (ovf_cnt)
    );

    // Behavioural divider: 8.8 / 8.8 -> 8.8, truncating, zero quotient on divide by zero.
    function automatic logic [16:0] div_model(input logic [15:0] a, input logic [15:0] b);
        int na;
        int nb;
        int q;
        na = int'($signed(a));
        nb = int'($signed(b));
        if (nb == 0) return {16'h0000, 1'b1};
        q = (na * 256) / nb;
        return {q[15:0], (q > 32767) || (q < -32768)};
    endfunction

    always @(posedge clk) begin
        dpipe[0] <= div_model(div_dividend, div_divisor);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end

    assign div_out      = dpipe[LAT-1][16:1];
    assign div_overflow = dpipe[LAT-1][0] | force_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every accepted output is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && o_valid && o_ready && !bulk) begin
            if (sb.size() == 0) begin
                check("unexpected_result", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result quot=%h ovf=%0d exp_quot=%h exp_ovf=%0d", o_quot, o_overflow, e.q, e.o);
                check("quot", o_quot, e.q);
                check("ovf", o_overflow, e.o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic eo, output int acc_cyc);
        i_valid = 1'b1;
        i_dividend = a;
        i_divisor = b;
        acc_cyc = -1;
        for (int n = 0; n < 200 && acc_cyc < 0; n++) begin
            @(negedge clk);
            if (i_ready) begin
                sb.push_back('{q: eq, o: eo});
                acc_cyc = cyc;
                $display("accept %h / %h at cycle %0d", a, b, cyc);
            end
            tick();
        end
        i_valid = 1'b0;
        i_dividend = '0;
        i_divisor = '0;
        if (acc_cyc < 0) check("send_timeout", acc_cyc, 0);
    endtask

    task automatic burst(input int n, output int acc);
        acc = 0;
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_dividend = 16'((acc + 1) * 256 + 64);
            i_divisor = 16'h0200;
            @(negedge clk);
            if (i_ready) begin
                sb.push_back('{q: 16'((acc + 1) * 128 + 32), o: 1'b0});
                acc++;
            end
            tick();
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 400 && sb.size() != 0; n++) tick();
        repeat (2) tick();
        check(name, sb.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ac;
        int seen;
        int acc;
        int bad;
        logic [15:0] exp_dz;
        logic [15:0] exp_big;
`ifdef FXP_DIV_SAT_EN
        exp_dz  = 16'h8000;
        exp_big = 16'h7FFF;
`else
        exp_dz  = 16'h0000;
        exp_big = 16'h8000;
`endif

        // Reset state
        tick();
        @(negedge clk);
        check("rst_o_valid", o_valid, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_i_ready", i_ready, 1);
        tick();

        // Single operation and its latency
        o_ready = 1'b1;
        send(16'h0100, 16'h0080, 16'h0200, 1'b0, ac);
        seen = -1;
        for (int n = 0; n < 4 * LAT && seen < 0; n++) begin
            @(negedge clk);
            if (o_valid) seen = cyc;
        end
        check("latency", seen - ac, LAT + 1);
        tick();
        drain("single_drain");

        // Signs, truncation, divide by zero, and positive overflow
        send(16'hFF00, 16'h0200, 16'hFF80, 1'b0, ac);
        send(16'h0100, 16'h0300, 16'h0055, 1'b0, ac);
        send(16'h8bb5, 16'h0000, exp_dz,   1'b1, ac);
        send(16'h4000, 16'h0080, exp_big,  1'b1, ac);
        drain("vectors_drain");
        check("ovf_cnt_two", ovf_cnt, 2);

        // Backpressure: only DEPTH accepts while the output is stalled
        o_ready = 1'b0;
        burst(40, acc);
        check("bp_accepts", acc, DEPTH);
        i_dividend = 16'(33 * 256 + 64);
        repeat (2 * LAT) tick();
        @(negedge clk);
        check("bp_ready_low", i_ready, 0);

        // Credit boundary: pop with i_valid held, accept follows on the next cycle
        tick();
        o_ready = 1'b1;
        @(negedge clk);
        check("boundary_pop_cycle_ready", i_ready, 0);
        tick();
        o_ready = 1'b0;
        @(negedge clk);
        check("boundary_accept_ready", i_ready, 1);
        if (i_ready) sb.push_back('{q: 16'(33 * 128 + 32), o: 1'b0});
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("boundary_credit_zero", i_ready, 0);
        tick();
        o_ready = 1'b1;
        drain("bp_drain");

        // Reset in the middle of five in-flight operations
        for (int k = 0; k < 5; k++)
            send(16'h0300, 16'h0100, 16'h0300, 1'b0, ac);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_i_ready", i_ready, 0);
        check("midrst_o_valid", o_valid, 0);
        tick();
        rst = 1'b1;
        bad = 0;
        for (int n = 0; n < 2 * LAT; n++) begin
            @(negedge clk);
            if (o_valid) bad++;
        end
        check("post_rst_quiet", bad, 0);
        check("post_rst_ovf_cnt", ovf_cnt, 0);
        tick();
        o_ready = 1'b0;
        burst(40, acc);
        check("rst_credit", acc, DEPTH);
        i_valid = 1'b0;
        o_ready = 1'b1;
        drain("rst_drain");

        // Saturation of the overflow counter
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bulk = 1'b1;
        force_ovf = 1'b1;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_dividend = 16'h0100;
        i_divisor = 16'h0100;
        repeat (70000) tick();
        i_valid = 1'b0;
        repeat (3 * LAT) tick();
        @(negedge clk);
        check("ovf_cnt_sat", ovf_cnt, 16'hFFFF);
        check("bulk_drained", o_valid, 0);
        force_ovf = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_fxp_div_stream.md
PIPE_FXP_DIV_STREAM -- requirements
Module: pipe_fxp_div_stream

Interface
REQ-001 SHALL have parameter WIIA, default 8: dividend integer bits.
REQ-002 SHALL have parameter WIFA, default 8: dividend fraction bits.
REQ-003 SHALL have parameter WIIB, default 8: divisor integer bits.
REQ-004 SHALL have parameter WIFB, default 8: divisor fraction bits.
REQ-005 SHALL have parameter WOI, default 8: quotient integer bits.
REQ-006 SHALL have parameter WOF, default 8: quotient fraction bits.
REQ-007 SHALL have parameter LAT, default 16: fixed latency of the attached free-running divider, in cycles.
REQ-008 SHALL have parameter DEPTH, default 32: result FIFO entries, and SHALL require DEPTH >= LAT+1.
REQ-009 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-011 SHALL have port i_valid, input, 1 bit: operand pair valid.
REQ-012 SHALL have port i_ready, output, 1 bit: operand pair accepted when high together with i_valid.
REQ-013 SHALL have port i_dividend, input, WIIA+WIFA bits: signed dividend.
REQ-014 SHALL have port i_divisor, input, WIIB+WIFB bits: signed divisor.
REQ-015 SHALL have port div_dividend, output, WIIA+WIFA bits: dividend driven to the divider.
REQ-016 SHALL have port div_divisor, output, WIIB+WIFB bits: divisor driven to the divider.
REQ-017 SHALL have port div_out, input, WOI+WOF bits: quotient returned by the divider.
REQ-018 SHALL have port div_overflow, input, 1 bit: overflow flag returned by the divider.
REQ-019 SHALL have port o_valid, output, 1 bit: result available at the FIFO head.
REQ-020 SHALL have port o_ready, input, 1 bit: downstream takes the result when high together with o_valid.
REQ-021 SHALL have port o_quot, output, WOI+WOF bits: signed quotient.
REQ-022 SHALL have port o_overflow, output, 1 bit: overflow flag belonging to o_quot.
REQ-023 SHALL have port ovf_cnt, output, 16 bits: saturating count of overflowed results written to the FIFO.

Function
REQ-024 SHALL set i_ready = (credit != 0), where credit is a counter of free FIFO slots not already claimed by in-flight operations; i_ready SHALL NOT depend on i_valid.
REQ-025 SHALL, on accept, decrement credit and drive i_dividend/i_divisor on div_dividend/div_divisor that same cycle; when not accepting, it SHALL drive zeros on both.
REQ-026 SHALL increment credit on a pop (o_valid & o_ready); an accept and a pop in the same cycle SHALL leave credit unchanged.
REQ-027 SHALL shift a LAT-deep valid delay line, carrying the quotient sign (dividend MSB XOR divisor MSB), once every cycle, unconditionally.
REQ-028 SHALL write {div_out, div_overflow} into the FIFO in the cycle the delay-line tap is 1 (exactly LAT cycles after accept); div_out SHALL be ignored in all other cycles.
REQ-029 SHALL, because of the credit rule, never write to a full FIFO; o_valid = !empty; o_quot and o_overflow SHALL come from the FIFO head; results SHALL leave in strict accept order.
REQ-030 SHALL provide a minimum end-to-end latency of LAT+1 cycles from accept to o_valid, and SHALL sustain 1 result/cycle while o_ready stays high.
REQ-031 SHALL increment ovf_cnt on each FIFO write whose overflow bit is 1, holding at 16'hFFFF.
REQ-032 SHALL handle a write to and a pop from the FIFO in the same cycle with both taking effect.

Reset
REQ-033 SHALL, while rst==0 at a clock edge, clear credit to DEPTH, the delay line to 0, the FIFO to empty, and ovf_cnt to 0; o_valid=0 and i_ready=0 during the reset cycle.
REQ-034 SHALL drop every in-flight and buffered result on a reset applied mid-operation; divider outputs arriving after reset SHALL be discarded.

Configuration
REQ-035 SHALL, with FXP_DIV_SAT_EN defined, write a saturated quotient into the FIFO when div_overflow=1: max positive (0x7FFF at 8.8) for a sign bit of 0, min negative (0x8000) for a sign bit of 1; o_overflow SHALL still be 1.
REQ-036 SHALL, with FXP_DIV_SAT_EN undefined, write div_out unmodified, and the sign bit SHALL be omitted from the delay line.

Structure
REQ-037 SHALL place the FIFO entry typedef ({quot, ovf}) and the saturation constants in the shared package fxp_div_pkg.
REQ-038 SHALL implement the FIFO as the sub-module fxp_sync_fifo, parameterized by width and DEPTH.

Verification
REQ-039 SHALL cover single op: 0x0100 / 0x0080 -> o_quot 0x0200, o_valid exactly LAT+1 cycles after accept, o_overflow 0.
REQ-040 SHALL cover divide by zero with FXP_DIV_SAT_EN defined: 0x8bb5 / 0x0000 -> o_quot 0x8000, o_overflow 1, ovf_cnt 1.
REQ-041 SHALL cover backpressure: o_ready=0 with 40 pairs offered -> exactly 32 accepted and i_ready 0 afterwards; then o_ready=1 -> all 32 results emerge in order.
REQ-042 SHALL cover a full credit boundary (credit 0, then a pop and i_valid in the same cycle) -> accept in the next cycle, credit stays at 0, no FIFO overflow.
REQ-043 SHALL cover reset after 5 accepts, mid-flight -> o_valid stays 0 for the following 2*LAT cycles and credit returns to 32.
REQ-044 SHALL cover 70000 forced overflows -> ovf_cnt holds at 0xFFFF.
